// File: rtl/tohost_ctrl_pkg.sv
// Shared types for the tohost harness controller: state encoding, default tohost address
// and the exit-store predicate.
package harness_pkg;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_1000;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SIG_REQ,
    ST_SIG_WAIT,
    ST_SIG_OUT,
    ST_DONE
  } tohost_state_e;

  // A full-word store to tohost with the LSB set terminates the test.
  function automatic logic is_exit_store(input logic [31:0] addr,
                                         input logic [3:0]  wsel,
                                         input logic [31:0] wdata,
                                         input logic [31:0] tohost_addr);
    return (addr == tohost_addr) && (wsel == 4'b1111) && wdata[0];
  endfunction

endpackage

// File: rtl/tohost_ctrl_if.sv
// Bundle of the controller's snoop, signature-memory, stream and result signals.
// slave = the controller, master = the surrounding harness.
interface tohost_ctrl_if #(
  parameter int SIG_AW = 14
);
  logic [31:0]       dmem_addr_i;
  logic [3:0]        dmem_wsel_byte_i;
  logic [31:0]       dmem_wdata_i;
  logic [31:0]       begin_sig_i;
  logic [31:0]       end_sig_i;
  logic              sig_rd_en_o;
  logic [SIG_AW-1:0] sig_rd_addr_o;
  logic [31:0]       sig_rd_data_i;
  logic              sig_valid_o;
  logic [31:0]       sig_data_o;
  logic              sig_ready_i;
  logic              done_o;
  logic              pass_o;
  logic              timeout_o;
  logic [30:0]       exit_code_o;
  logic [31:0]       tick_count_o;

  modport slave (
    input  dmem_addr_i, dmem_wsel_byte_i, dmem_wdata_i, begin_sig_i, end_sig_i,
           sig_rd_data_i, sig_ready_i,
    output sig_rd_en_o, sig_rd_addr_o, sig_valid_o, sig_data_o,
           done_o, pass_o, timeout_o, exit_code_o, tick_count_o
  );

  modport master (
    output dmem_addr_i, dmem_wsel_byte_i, dmem_wdata_i, begin_sig_i, end_sig_i,
           sig_rd_data_i, sig_ready_i,
    input  sig_rd_en_o, sig_rd_addr_o, sig_valid_o, sig_data_o,
           done_o, pass_o, timeout_o, exit_code_o, tick_count_o
  );
endinterface

// File: rtl/tohost_ctrl_sig_streamer.sv
// Streams signature words [begin, end) from a 1-cycle-latency memory over valid/ready.
// Three cycles per word (REQ, WAIT, OUT); each ready-low cycle in OUT adds one.
module sig_streamer
  import harness_pkg::*;
#(
  parameter int SIG_AW = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_start,
  input  logic [SIG_AW-1:0] i_begin_word,
  input  logic [SIG_AW-1:0] i_end_word,
  output logic              o_empty,
  output logic              o_finished,
  output logic              o_rd_en,
  output logic [SIG_AW-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_valid,
  output logic [31:0]       o_data,
  input  logic              i_ready
);

  // ST_DONE doubles as the idle state between runs.
  tohost_state_e     r_state;
  logic [SIG_AW-1:0] r_ptr;
  logic [SIG_AW-1:0] r_last;
  logic              r_rd_en;
  logic [SIG_AW-1:0] r_rd_addr;
  logic              r_valid;
  logic [31:0]       r_data;
  logic [SIG_AW-1:0] w_ptr_nxt;

  assign w_ptr_nxt  = r_ptr + SIG_AW'(1);
  assign o_empty    = (i_begin_word >= i_end_word);
  assign o_finished = (r_state == ST_SIG_OUT) && i_ready && (w_ptr_nxt == r_last);
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_DONE;
      r_ptr     <= '0;
      r_last    <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        ST_DONE: begin
          if (i_start) begin
            r_ptr     <= i_begin_word;
            r_last    <= i_end_word;
            r_rd_addr <= i_begin_word;
            r_rd_en   <= 1'b1;
            r_state   <= ST_SIG_REQ;
          end
        end
        ST_SIG_REQ: begin
          r_rd_en <= 1'b0;
          r_state <= ST_SIG_WAIT;
        end
        ST_SIG_WAIT: begin
          r_data  <= i_rd_data;
          r_valid <= 1'b1;
          r_state <= ST_SIG_OUT;
        end
        ST_SIG_OUT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            if (w_ptr_nxt == r_last) begin
              r_state <= ST_DONE;
            end else begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_ptr_nxt;
              r_state   <= ST_SIG_REQ;
            end
          end
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: rtl/tohost_ctrl.sv
// Test-harness controller: snoops tohost exit stores, enforces a cycle budget, then
// streams the signature region; results freeze in DONE until reset.
module tohost_ctrl
  import harness_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int          MAX_TICKS   = 100000,
  parameter int          SIG_AW      = 14
) (
  input logic          clk_i,
  input logic          rst_i,
  tohost_ctrl_if.slave bus
);

  localparam logic [31:0] LP_LAST_TICK = 32'(MAX_TICKS - 1);

  // Top-level state uses ST_SIG_REQ to mean "signature phase"; the streamer owns the sub-steps.
  tohost_state_e r_state;
  logic [31:0]   r_tick;
  logic          r_pass;
  logic          r_timeout;
  logic [30:0]   r_exit_code;
  logic          r_done;

  logic              w_exit;
  logic              w_timeout;
  logic              w_leave_run;
  logic              w_empty;
  logic              w_start;
  logic              w_finished;
  logic [SIG_AW-1:0] w_begin_word;
  logic [SIG_AW-1:0] w_end_word;
  logic              w_unused_bits;

  assign w_begin_word  = bus.begin_sig_i[SIG_AW+1:2];
  assign w_end_word    = bus.end_sig_i[SIG_AW+1:2];
  assign w_unused_bits = ^{bus.begin_sig_i[31:SIG_AW+2], bus.begin_sig_i[1:0],
                           bus.end_sig_i[31:SIG_AW+2], bus.end_sig_i[1:0]};

  assign w_exit      = is_exit_store(bus.dmem_addr_i, bus.dmem_wsel_byte_i,
                                     bus.dmem_wdata_i, TOHOST_ADDR);
  assign w_timeout   = (r_tick == LP_LAST_TICK);
  assign w_leave_run = (r_state == ST_RUN) && (w_exit || w_timeout);
  assign w_start     = w_leave_run && !w_empty;

  sig_streamer #(
    .SIG_AW(SIG_AW)
  ) u_streamer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_start     (w_start),
    .i_begin_word(w_begin_word),
    .i_end_word  (w_end_word),
    .o_empty     (w_empty),
    .o_finished  (w_finished),
    .o_rd_en     (bus.sig_rd_en_o),
    .o_rd_addr   (bus.sig_rd_addr_o),
    .i_rd_data   (bus.sig_rd_data_i),
    .o_valid     (bus.sig_valid_o),
    .o_data      (bus.sig_data_o),
    .i_ready     (bus.sig_ready_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_tick      <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_exit_code <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_tick <= r_tick + 32'd1;
          if (w_exit) begin
            r_exit_code <= bus.dmem_wdata_i[31:1];
            r_pass      <= (bus.dmem_wdata_i == 32'd1);
          end else if (w_timeout) begin
            r_timeout <= 1'b1;
          end
          // An empty signature range skips streaming entirely.
          if (w_leave_run) begin
            r_state <= w_empty ? ST_DONE : ST_SIG_REQ;
            r_done  <= w_empty;
          end
        end
        ST_SIG_REQ: begin
          if (w_finished) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.done_o       = r_done;
  assign bus.pass_o       = r_pass;
  assign bus.timeout_o    = r_timeout;
  assign bus.exit_code_o  = r_exit_code;
  assign bus.tick_count_o = r_tick;

endmodule

// File: tb/tb_tohost_ctrl.sv
// Directed bench for tohost_ctrl with a scoreboard of expected signature words/addresses.
module tb_tohost_ctrl;
  import harness_pkg::*;

  localparam int          AW   = 14;
  localparam int          MAXT = 64;
  localparam logic [31:0] TH   = TOHOST_ADDR_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tohost_ctrl_if #(.SIG_AW(AW)) bus ();

  tohost_ctrl #(
    .TOHOST_ADDR(TH),
    .MAX_TICKS  (MAXT),
    .SIG_AW     (AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [31:0]     exp_q[$];
  logic [AW-1:0]   addr_q[$];
  int              words = 0;
  int              vld_cycles = 0;
  logic            held_vld = 1'b0;
  logic [31:0]     held_dat = '0;
  logic            rand_rdy = 1'b0;
  logic            rdy_rand = 1'b1;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], 8'hC3, 2'b01, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory with fixed 1-cycle read latency; poison value when no read was issued.
  always @(posedge clk)
    bus.sig_rd_data_i <= bus.sig_rd_en_o ? mem_word(bus.sig_rd_addr_o) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end
  assign bus.sig_ready_i = rand_rdy ? rdy_rand : 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (bus.sig_rd_en_o) begin
        check("rd_addr_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("rd_addr", 32'(bus.sig_rd_addr_o), 32'(addr_q.pop_front()));
      end
      if (bus.sig_valid_o) begin
        vld_cycles++;
        if (held_vld) check("hold_stable", bus.sig_data_o, held_dat);
        if (bus.sig_ready_i) begin
          words++;
          held_vld = 1'b0;
          check("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("word", bus.sig_data_o, exp_q.pop_front());
        end else begin
          held_vld = 1'b1;
          held_dat = bus.sig_data_o;
        end
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  // Asserts reset mid-cycle, checks outputs cleared asynchronously, then releases.
  task automatic start_run(input logic [31:0] b, input logic [31:0] e);
    rst = 1'b1;
    bus.begin_sig_i = b;
    bus.end_sig_i   = e;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("rst_done",      32'(bus.done_o),        32'd0);
    check("rst_pass",      32'(bus.pass_o),        32'd0);
    check("rst_timeout",   32'(bus.timeout_o),     32'd0);
    check("rst_exit_code", 32'(bus.exit_code_o),   32'd0);
    check("rst_tick",      bus.tick_count_o,       32'd0);
    check("rst_valid",     32'(bus.sig_valid_o),   32'd0);
    check("rst_data",      bus.sig_data_o,         32'd0);
    check("rst_rd_en",     32'(bus.sig_rd_en_o),   32'd0);
    check("rst_rd_addr",   32'(bus.sig_rd_addr_o), 32'd0);
    for (int a = int'(b[AW+1:2]); a < int'(e[AW+1:2]); a++) begin
      addr_q.push_back(AW'(a));
      exp_q.push_back(mem_word(AW'(a)));
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bus.dmem_addr_i      = a;
    bus.dmem_wsel_byte_i = w;
    bus.dmem_wdata_i     = d;
    @(posedge clk);
    #1;
    bus.dmem_addr_i      = '0;
    bus.dmem_wsel_byte_i = '0;
    bus.dmem_wdata_i     = '0;
  endtask

  task automatic wait_tick(input int t);
    for (int i = 0; i < 1000 && bus.tick_count_o != 32'(t); i++) begin
      @(posedge clk);
      #1;
    end
    check("tick_reach", bus.tick_count_o, 32'(t));
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (!bus.done_o && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("done_reached", 32'(bus.done_o), 32'd1);
  endtask

  initial begin
    int cnt;
    int w0;
    int v0;
    bus.dmem_addr_i      = '0;
    bus.dmem_wsel_byte_i = '0;
    bus.dmem_wdata_i     = '0;
    bus.begin_sig_i      = '0;
    bus.end_sig_i        = '0;

    // Pass at tick 50, four words 0x800..0x803, done 12 cycles after the exit edge.
    start_run(32'h8000_2000, 32'h8000_2010);
    wait_tick(50);
    w0 = words;
    drive_store(TH, 4'b1111, 32'h1);
    check("t1_pass",    32'(bus.pass_o),      32'd1);
    check("t1_exit",    32'(bus.exit_code_o), 32'd0);
    check("t1_timeout", 32'(bus.timeout_o),   32'd0);
    check("t1_tick",    bus.tick_count_o,     32'd51);
    check("t1_rd_en",   32'(bus.sig_rd_en_o), 32'd1);
    wait_done(100, cnt);
    check("t1_done_lat", 32'(cnt),            32'd12);
    check("t1_words",    32'(words - w0),     32'd4);
    check("t1_sb_empty", 32'(exp_q.size()),   32'd0);
    check("t1_tick_frz", bus.tick_count_o,    32'd51);

    // Ignored stores, then exit code 3.
    start_run(32'h8000_2000, 32'h8000_2008);
    wait_tick(5);
    w0 = words;
    drive_store(TH, 4'b1111, 32'h6);
    check("t2_even_rd_en", 32'(bus.sig_rd_en_o), 32'd0);
    check("t2_even_exit",  32'(bus.exit_code_o), 32'd0);
    drive_store(TH, 4'b0001, 32'h1);
    check("t2_byte_rd_en", 32'(bus.sig_rd_en_o), 32'd0);
    check("t2_byte_pass",  32'(bus.pass_o),      32'd0);
    drive_store(TH + 32'd4, 4'b1111, 32'h1);
    check("t2_addr_rd_en", 32'(bus.sig_rd_en_o), 32'd0);
    drive_store(TH, 4'b1111, 32'h7);
    check("t2_pass",       32'(bus.pass_o),      32'd0);
    check("t2_exit",       32'(bus.exit_code_o), 32'd3);
    check("t2_tick",       bus.tick_count_o,     32'd9);
    wait_done(100, cnt);
    check("t2_done_lat",   32'(cnt),             32'd6);
    check("t2_words",      32'(words - w0),      32'd2);

    // Timeout with no exit store; signature still streamed.
    start_run(32'h8000_2000, 32'h8000_2004);
    w0 = words;
    wait_done(MAXT + 50, cnt);
    check("t3_timeout", 32'(bus.timeout_o),   32'd1);
    check("t3_pass",    32'(bus.pass_o),      32'd0);
    check("t3_exit",    32'(bus.exit_code_o), 32'd0);
    check("t3_tick",    bus.tick_count_o,     32'(MAXT));
    check("t3_words",   32'(words - w0),      32'd1);

    // Exit store on the final tick beats the timeout.
    start_run(32'h8000_2000, 32'h8000_2004);
    wait_tick(MAXT - 1);
    drive_store(TH, 4'b1111, 32'h3);
    check("t3b_timeout", 32'(bus.timeout_o),   32'd0);
    check("t3b_exit",    32'(bus.exit_code_o), 32'd1);
    check("t3b_pass",    32'(bus.pass_o),      32'd0);
    check("t3b_tick",    bus.tick_count_o,     32'(MAXT));
    wait_done(100, cnt);
    check("t3b_done_lat", 32'(cnt),            32'd3);

    // Random backpressure over eight words.
    start_run(32'h8000_2040, 32'h8000_2060);
    rand_rdy = 1'b1;
    wait_tick(3);
    w0 = words;
    drive_store(TH, 4'b1111, 32'h1);
    wait_done(600, cnt);
    rand_rdy = 1'b0;
    check("t4_min_lat",  32'(cnt >= 24),     32'd1);
    check("t4_words",    32'(words - w0),    32'd8);
    check("t4_sb_empty", 32'(exp_q.size()),  32'd0);

    // Empty range: done right after the exit edge, no valid ever.
    start_run(32'h8000_2000, 32'h8000_2000);
    wait_tick(4);
    v0 = vld_cycles;
    drive_store(TH, 4'b1111, 32'h1);
    check("t5_done_now", 32'(bus.done_o),     32'd1);
    check("t5_rd_en",    32'(bus.sig_rd_en_o), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_valid", 32'(vld_cycles - v0), 32'd0);
    check("t5_done_hold", 32'(bus.done_o),     32'd1);

    // Reset after word 2, then a full rerun from word 0.
    start_run(32'h8000_2000, 32'h8000_2010);
    wait_tick(2);
    w0 = words;
    drive_store(TH, 4'b1111, 32'h1);
    for (int i = 0; i < 50 && (words - w0) < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_two_words", 32'(words - w0), 32'd2);
    #2;
    start_run(32'h8000_2000, 32'h8000_2010);
    wait_tick(2);
    w0 = words;
    drive_store(TH, 4'b1111, 32'h1);
    wait_done(100, cnt);
    check("t6_done_lat",  32'(cnt),          32'd12);
    check("t6_words",     32'(words - w0),   32'd4);
    check("t6_sb_empty",  32'(exp_q.size()), 32'd0);
    check("t6_addr_empty", 32'(addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tohost_ctrl.md
# tohost_ctrl

Simulation-harness controller that sits downstream of the core's data-memory port, alongside the dual-port test memory. It snoops data-side stores for a write to the `tohost` address, records pass/fail and exit code, and enforces a cycle-budget timeout. It then streams the memory signature region out word by word over a valid/ready interface for the bench to write to file.

## Interface

Parameters:
- `TOHOST_ADDR`, 32'h8000_1000: byte address of the `tohost` word.
- `MAX_TICKS`, 100000: RUN-state cycle budget before timeout.
- `SIG_AW`, 14: word-address width of the test memory.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `dmem_addr_i`  in  32  core data address (snooped).
- `dmem_wsel_byte_i`  in  4  store byte enables; nonzero means a store.
- `dmem_wdata_i`  in  32  store data.
- `begin_sig_i`  in  32  signature start byte address; quasi-static.
- `end_sig_i`  in  32  signature end byte address, exclusive; quasi-static.
- `sig_rd_en_o`  out  1  memory read enable.
- `sig_rd_addr_o`  out  SIG_AW  memory word address.
- `sig_rd_data_i`  in  32  memory read data, valid 1 cycle after `sig_rd_en_o`.
- `sig_valid_o`  out  1  signature word available.
- `sig_data_o`  out  32  signature word.
- `sig_ready_i`  in  1  bench accepts the word.
- `done_o`  out  1  sticky; the run is complete and the signature is fully streamed.
- `pass_o`  out  1  `tohost` value was 1 (exit code 0).
- `timeout_o`  out  1  the budget expired before any `tohost` exit.
- `exit_code_o`  out  31  `dmem_wdata_i[31:1]` of the exit store.
- `tick_count_o`  out  32  number of cycles spent in RUN.

## Operation

- States: RUN, SIG_REQ, SIG_WAIT, SIG_OUT, DONE. Reset enters RUN.
- RUN:
  - `tick_count_o` increments by 1 every cycle.
  - An exit store is `dmem_addr_i == TOHOST_ADDR` and `dmem_wsel_byte_i == 4'b1111` and `dmem_wdata_i[0] == 1`.
  - On an exit store: latch `exit_code_o = wdata[31:1]` and `pass_o = (wdata == 1)`, then go to the signature phase.
  - Stores with `wdata[0] == 0`, partial stores, or stores to other addresses are ignored.
- Timeout: in RUN, if `tick_count_o == MAX_TICKS - 1` and there is no exit store, set `timeout_o = 1`, leave `pass_o = 0`, and go to the signature phase.
- Simultaneous exit store and timeout: the exit store wins and `timeout_o` stays 0.
- Entering the signature phase:
  - Sample `ptr = begin_sig_i[SIG_AW+1:2]` and `last = end_sig_i[SIG_AW+1:2]`.
  - If `ptr >= last`, go directly to DONE with no words streamed. Otherwise go to SIG_REQ.
- SIG_REQ: drive `sig_rd_en_o = 1` and `sig_rd_addr_o = ptr` for 1 cycle, then go to SIG_WAIT.
- SIG_WAIT: capture `sig_rd_data_i` into `sig_data_o`, set `sig_valid_o`, and go to SIG_OUT.
- SIG_OUT:
  - Hold `sig_valid_o` and `sig_data_o` stable until `sig_ready_i`.
  - On handshake: `ptr <= ptr + 1` and deassert valid.
  - If `ptr + 1 == last`, go to DONE; else go to SIG_REQ.
- DONE:
  - `done_o = 1`; the block stays here until reset.
  - Further stores are ignored and all result outputs are frozen.
- `ptr` is SIG_AW bits wide; end of range is detected by equality, so there is no wrap-around.
- Reset at any point (including mid-stream) returns the block to RUN, clears all outputs, and discards any in-flight read.

## Timing

- Reset values: every output is 0, including `tick_count_o`, `exit_code_o` and `sig_rd_addr_o`.
- Exit store sampled at edge N: `pass_o`/`exit_code_o` are visible after edge N, and `sig_rd_en_o` is high in cycle N+1.
- Per-word cost is 3 cycles minimum (REQ, WAIT, OUT) with `sig_ready_i` held high. Each cycle of ready low adds 1 cycle.
- With ready held high, `done_o` rises 3·(last−ptr) cycles after the exit store edge. With an empty range it rises on the cycle after the exit store.
- `sig_ready_i` asserted while `sig_valid_o == 0` has no effect.
- The memory read port has a fixed 1-cycle latency; no read is issued while a word is held in SIG_OUT.

## Structure

- Package `harness_pkg` holds:
  - the state enum `tohost_state_e`;
  - `TOHOST_ADDR_DEFAULT`;
  - the exit-store predicate as a function.
- Sub-module `sig_streamer` holds the SIG_REQ/SIG_WAIT/SIG_OUT FSM and `ptr`, started by a 1-cycle `start` pulse and reporting `finished`.
- The top level keeps RUN/DONE, the tick counter, and the result registers.

## Test plan

- Store 32'h1 to TOHOST_ADDR at tick 50, with begin=0x8000_2000 and end=0x8000_2010 → `pass_o=1`, `exit_code_o=0`, and exactly 4 words streamed from word addresses 0x800..0x803 in order. `done_o` rises 12 cycles after the store.
- Store 32'h7 to `tohost` → `pass_o=0` and `exit_code_o=3`. A preceding store of 32'h6 and a byte store (wsel=4'b0001) of 0x01 are both ignored.
- No store with MAX_TICKS=20 → `timeout_o=1`, `pass_o=0`, `tick_count_o=20`, signature still streamed. A store on the final tick instead gives `timeout_o=0`.
- `sig_ready_i` toggled pseudo-randomly → no word lost or duplicated, and `sig_data_o` stays stable while valid and not ready.
- begin == end → `done_o` the cycle after the exit store, and `sig_valid_o` never asserts.
- `rst_i` pulsed mid-stream (after word 2) → all outputs 0 asynchronously. A rerun after reset streams the full signature again from word 0.
